// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA scan path.
// Provides the 640x480@60 default timing, derived totals and sync windows,
// counter/coordinate widths and the packed {r,g,b} colour layout.
package vga_pkg;

  // Default 640x480@60 timing (pixels / lines).
  localparam int unsigned DEF_PIX_DIV  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Total length of one axis, active region plus all blanking.
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  localparam int unsigned DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Widths.
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned CH_W    = 4;
  localparam int unsigned COLOR_W = 3 * CH_W;

  // Colour field slice positions within the 12-bit word.
  localparam int unsigned R_LSB = 2 * CH_W;
  localparam int unsigned G_LSB = CH_W;
  localparam int unsigned B_LSB = 0;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : advance the count by one position
//   cnt        : current position 0..TOTAL-1
//   active     : cnt is inside the visible region
//   sync_n     : active-low sync, low for cnt in [ACTIVE+FP, ACTIVE+FP+SYNC)
//   wrap       : cnt is at TOTAL-1 (next en returns to 0)
// All decodes are registered alongside cnt from its next value, so they
// always describe the current cnt.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync_n,
  output logic             wrap
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  logic [CNT_W-1:0] cnt_nxt;

  // Next position: hold, step, or return to 0 after the last position.
  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  // Position register plus decodes of the position being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b1;
      sync_n <= 1'b1;
      wrap   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      active <= (cnt_nxt < CNT_W'(ACTIVE));
      sync_n <= !((cnt_nxt >= CNT_W'(SYNC_START)) && (cnt_nxt < CNT_W'(SYNC_END)));
      wrap   <= (cnt_nxt == CNT_W'(TOTAL - 1));
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing generator and pin driver.
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   vga_color         : renderer colour for (x_count, y_count), {r,g,b}
//   x_count, y_count  : visible coordinate, 0 during blanking
//   pix_tick          : one-clk pulse after each coordinate advance
//   frame_tick        : one-clk pulse on entry to vertical blank
//   video_on          : coordinate is visible
//   hsync, vsync      : active-low syncs, aligned with RGB
//   vga_r/g/b         : pixel colour, 0 while blanked
// Pipeline: stage 0 registers coordinate and raw syncs on pix_en; the
// renderer's colour is sampled mid-pixel; stage 1 drives the pins one pixel
// later so syncs and colour for the same pixel leave together.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] vga_color,
  output logic [X_W-1:0]     x_count,
  output logic [Y_W-1:0]     y_count,
  output logic               pix_tick,
  output logic               frame_tick,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic [CH_W-1:0]    vga_r,
  output logic [CH_W-1:0]    vga_g,
  output logic [CH_W-1:0]    vga_b
);

  localparam int unsigned DIV_W = $clog2(PIX_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic             sample_en;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_active;
  logic             v_active;
  logic             h_sync_n;
  logic             v_sync_n;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_en;

  logic             hs_q;
  logic             vs_q;
  rgb_t             color_q;

  // The vertical counter wraps on its own; its wrap flag has no consumer here.
  logic             unused_v_wrap;
  assign unused_v_wrap = v_wrap;

  // Pixel strobe at the end of each divider period; colour is sampled one
  // clk earlier so the renderer has the rest of the pixel to settle.
  assign pix_en    = (div_cnt == DIV_W'(PIX_DIV - 1));
  assign sample_en = (div_cnt == DIV_W'(PIX_DIV - 2));
  assign v_en      = pix_en && h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pix_en),
    .cnt    (h_cnt),
    .active (h_active),
    .sync_n (h_sync_n),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (v_en),
    .cnt    (v_cnt),
    .active (v_active),
    .sync_n (v_sync_n),
    .wrap   (v_wrap)
  );

  // Divider, ticks, colour sample, stage 0 and stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      pix_tick   <= 1'b0;
      frame_tick <= 1'b0;
      color_q    <= '0;
      x_count    <= '0;
      y_count    <= '0;
      video_on   <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
    end else begin
      div_cnt    <= pix_en ? '0 : div_cnt + DIV_W'(1);
      pix_tick   <= pix_en;
      // Last pixel of the last visible line: next position starts vblank.
      frame_tick <= pix_en && h_wrap && (v_cnt == CNT_W'(V_ACTIVE - 1));

      if (sample_en) begin
        color_q <= rgb_t'(vga_color);
      end

      if (pix_en) begin
        x_count  <= h_active ? X_W'(h_cnt) : '0;
        y_count  <= v_active ? Y_W'(v_cnt) : '0;
        video_on <= h_active && v_active;
        hs_q     <= h_sync_n;
        vs_q     <= v_sync_n;

        hsync    <= hs_q;
        vsync    <= vs_q;
        vga_r    <= video_on ? color_q.r : '0;
        vga_g    <= video_on ? color_q.g : '0;
        vga_b    <= video_on ? color_q.b : '0;
      end
    end
  end

endmodule
